pipe_control: RTL and testbench

PIPE_CONTROL -- requirements
Module: pipe_control

---
 rtl/y86_pkg.sv | 25 ++
 rtl/pipe_hazard_detect.sv | 45 ++++
 rtl/pipe_control.sv | 100 ++++++++++
 tb/tb_pipe_control.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 encodings used by the pipeline control logic.
package y86_pkg;

    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] RNONE    = 4'hF;

    typedef enum logic [1:0] {
        AOK = 2'd0,
        HLT = 2'd1,
        ADR = 2'd2,
        INS = 2'd3
    } stat_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2,
        S_FAULT  = 2'd3
    } run_state_e;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational hazard detection and RUN-mode pipeline register controls.
module pipe_hazard_detect
    import y86_pkg::*;
(
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_dstM,
    input  logic       e_Cnd,
    input  logic [3:0] M_icode,
    input  logic [1:0] m_stat,
    input  logic [1:0] W_stat,
    output logic       loaduse,
    output logic       mispred,
    output logic       F_stall,
    output logic       D_stall,
    output logic       D_bubble,
    output logic       E_bubble,
    output logic       M_bubble,
    output logic       W_stall,
    output logic       set_cc
);

    logic retpend;
    logic exc;

    always_comb begin
        loaduse = (E_icode == I_MRMOVQ || E_icode == I_POPQ) && (E_dstM != RNONE) &&
                  (E_dstM == d_srcA || E_dstM == d_srcB);
        retpend = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        mispred = (E_icode == I_JXX) && !e_Cnd;
        exc     = (m_stat != AOK) || (W_stat != AOK);

        F_stall  = loaduse | retpend;
        D_stall  = loaduse;
        // A load-use stall holds the ret in decode, so the ret bubble waits a cycle.
        D_bubble = mispred | (retpend & !loaduse);
        E_bubble = mispred | loaduse;
        M_bubble = exc;
        W_stall  = (W_stat != AOK);
        set_cc   = (E_icode == I_OPQ) && (m_stat == AOK) && (W_stat == AOK);
    end

endmodule

// File: rtl/pipe_control.sv
// Pipeline control: run/halt FSM, status latch, event counters, control muxing.
module pipe_control
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  E_dstM,
    input  logic        e_Cnd,
    input  logic [3:0]  M_icode,
    input  logic [1:0]  m_stat,
    input  logic [1:0]  W_stat,
    output logic        F_stall,
    output logic        D_stall,
    output logic        D_bubble,
    output logic        E_bubble,
    output logic        M_bubble,
    output logic        W_stall,
    output logic        set_cc,
    output logic [1:0]  run_state,
    output logic [1:0]  cpu_stat,
    output logic [31:0] cycle_count,
    output logic [15:0] stall_count,
    output logic [15:0] mispred_count
);

    run_state_e state, state_nxt;
    logic loaduse, mispred;
    logic r_fs, r_ds, r_db, r_eb, r_mb, r_ws, r_cc;
    logic run_exit;

    pipe_hazard_detect u_hazard (
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
        .loaduse(loaduse), .mispred(mispred),
        .F_stall(r_fs), .D_stall(r_ds), .D_bubble(r_db), .E_bubble(r_eb),
        .M_bubble(r_mb), .W_stall(r_ws), .set_cc(r_cc)
    );

    assign run_exit  = (state == S_RUN) && (W_stat != AOK);
    assign run_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc} = 7'b1011100;
        case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN: begin
                {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc} =
                    {r_fs, r_ds, r_db, r_eb, r_mb, r_ws, r_cc};
                if (W_stat == HLT)                         state_nxt = S_HALTED;
                else if (W_stat == ADR || W_stat == INS)   state_nxt = S_FAULT;
            end
            default: begin
                {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc} = 7'b1101110;
                if (start) state_nxt = S_IDLE;
            end
        endcase
        // While reset is held the pipeline sits flushed regardless of state.
        if (rst) {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc} = 7'b1011100;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_stat      <= AOK;
            cycle_count   <= '0;
            stall_count   <= '0;
            mispred_count <= '0;
        end else begin
            if (run_exit)
                cpu_stat <= W_stat;
            else if (state_nxt == S_IDLE && state != S_IDLE)
                cpu_stat <= AOK;

            if (state == S_IDLE && start) begin
                cycle_count   <= '0;
                stall_count   <= '0;
                mispred_count <= '0;
            end else if (state == S_RUN) begin
                cycle_count <= cycle_count + 32'd1;
                // Event counters freeze on the exit cycle; the cycle counter does not.
                if (!run_exit) begin
                    if (loaduse && stall_count != 16'hFFFF)   stall_count   <= stall_count + 16'd1;
                    if (mispred && mispred_count != 16'hFFFF) mispred_count <= mispred_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control with a queue-based scoreboard of expected controls.
module tb_pipe_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  D_icode = 4'h0, d_srcA = 4'h0, d_srcB = 4'h0;
    logic [3:0]  E_icode = 4'h0, E_dstM = 4'h0, M_icode = 4'h0;
    logic        e_Cnd = 1'b0;
    logic [1:0]  m_stat = 2'd0, W_stat = 2'd0;
    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
    logic [1:0]  run_state, cpu_stat;
    logic [31:0] cycle_count;
    logic [15:0] stall_count, mispred_count;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string      tag;
        logic [6:0] ctl;
    } exp_t;
    exp_t sbq[$];

    logic [6:0] ctl_vec;
    assign ctl_vec = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};

    localparam logic [6:0] CTL_IDLE   = 7'b1011100;
    localparam logic [6:0] CTL_FREEZE = 7'b1101110;

    pipe_control dut (
        .clk(clk), .rst(rst), .start(start),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc),
        .run_state(run_state), .cpu_stat(cpu_stat), .cycle_count(cycle_count),
        .stall_count(stall_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push expected controls for the inputs just driven, then pop and compare.
    task automatic step(input string tag, input logic [6:0] ctl);
        exp_t e;
        sbq.push_back('{tag, ctl});
        #1;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            chk(e.tag, {25'd0, ctl_vec}, {25'd0, e.ctl});
        end
    endtask

    task automatic set_in(input logic [3:0] di, input logic [3:0] sa, input logic [3:0] sb,
                          input logic [3:0] ei, input logic [3:0] dm, input logic cnd,
                          input logic [3:0] mi, input logic [1:0] ms, input logic [1:0] ws);
        D_icode = di; d_srcA = sa; d_srcB = sb; E_icode = ei; E_dstM = dm;
        e_Cnd = cnd; M_icode = mi; m_stat = ms; W_stat = ws;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_state", {30'd0, run_state}, 32'd0);
        chk("rst_cpu_stat", {30'd0, cpu_stat}, 32'd0);
        chk("rst_cycles", cycle_count, 32'd0);
        step("rst_ctl", CTL_IDLE);
        tick();
        rst = 1'b0;
        tick();
        step("idle_ctl", CTL_IDLE);

        pulse_start();
        chk("run_entry", {30'd0, run_state}, 32'd1);
        chk("run_entry_cycles", cycle_count, 32'd0);

        set_in(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 2'd0); step("nop", 7'b0000000); tick();
        set_in(4'h0, 4'h0, 4'h0, 4'h6, 4'h0, 1'b0, 4'h0, 2'd0, 2'd0); step("opq_cc", 7'b0000001); tick();
        set_in(4'h0, 4'h3, 4'h0, 4'h5, 4'h3, 1'b0, 4'h0, 2'd0, 2'd0); step("loaduse", 7'b1101000); tick();
        set_in(4'h0, 4'hF, 4'h1, 4'h5, 4'hF, 1'b0, 4'h0, 2'd0, 2'd0); step("rnone_nomatch", 7'b0000000); tick();
        set_in(4'h0, 4'h0, 4'h0, 4'h7, 4'h0, 1'b0, 4'h0, 2'd0, 2'd0); step("mispred", 7'b0011000); tick();
        set_in(4'h0, 4'h0, 4'h0, 4'h7, 4'h0, 1'b1, 4'h0, 2'd0, 2'd0); step("jxx_taken", 7'b0000000); tick();
        set_in(4'h9, 4'h0, 4'h3, 4'hB, 4'h3, 1'b0, 4'h0, 2'd0, 2'd0); step("ret_loaduse", 7'b1101000); tick();
        set_in(4'h9, 4'h0, 4'h3, 4'h0, 4'h3, 1'b0, 4'h0, 2'd0, 2'd0); step("ret_after", 7'b1010000); tick();
        set_in(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h9, 2'd0, 2'd0); step("ret_in_m", 7'b1010000); tick();
        set_in(4'h0, 4'h0, 4'h0, 4'h6, 4'h0, 1'b0, 4'h0, 2'd2, 2'd0); step("m_exc", 7'b0000100); tick();
        chk("stall_cnt", {16'd0, stall_count}, 32'd2);
        chk("mispred_cnt", {16'd0, mispred_count}, 32'd1);
        chk("cycle_cnt", cycle_count, 32'd10);

        // Halt with a concurrent load-use: the stall must not be counted.
        set_in(4'h0, 4'h3, 4'h0, 4'h5, 4'h3, 1'b0, 4'h0, 2'd0, 2'd1); step("halt_cycle", 7'b1101110); tick();
        chk("halted_state", {30'd0, run_state}, 32'd2);
        chk("halted_stat", {30'd0, cpu_stat}, 32'd1);
        chk("exit_cycle_cnt", cycle_count, 32'd11);
        chk("exit_stall_cnt", {16'd0, stall_count}, 32'd2);
        set_in(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 2'd0); step("freeze_ctl", CTL_FREEZE); tick();
        chk("halted_hold", cycle_count, 32'd11);
        pulse_start();
        chk("restart_idle", {30'd0, run_state}, 32'd0);
        chk("restart_stat", {30'd0, cpu_stat}, 32'd0);
        step("idle_again", CTL_IDLE);

        pulse_start();
        chk("clear_stall", {16'd0, stall_count}, 32'd0);
        chk("clear_mispred", {16'd0, mispred_count}, 32'd0);
        set_in(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 2'd3); step("fault_cycle", 7'b0000110); tick();
        chk("fault_state", {30'd0, run_state}, 32'd3);
        chk("fault_stat", {30'd0, cpu_stat}, 32'd3);
        set_in(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 2'd0);
        pulse_start();
        pulse_start();

        // Mid-RUN reset with nonzero counters, asserted away from any edge.
        set_in(4'h0, 4'h2, 4'h0, 4'h5, 4'h2, 1'b0, 4'h0, 2'd0, 2'd0);
        tick(); tick(); tick();
        chk("pre_rst_stall", {16'd0, stall_count}, 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("async_state", {30'd0, run_state}, 32'd0);
        chk("async_cycles", cycle_count, 32'd0);
        chk("async_stall", {16'd0, stall_count}, 32'd0);
        step("async_ctl", CTL_IDLE);
        tick();
        chk("rst_hold_cycles", cycle_count, 32'd0);
        rst = 1'b0;
        tick();

        // Saturation: 65535 load-use cycles reach the ceiling, further ones stay there.
        pulse_start();
        repeat (65535) @(posedge clk);
        #1;
        chk("sat_reach", {16'd0, stall_count}, 32'h0000FFFF);
        tick(); tick();
        chk("sat_hold", {16'd0, stall_count}, 32'h0000FFFF);
        chk("sat_cycles", cycle_count, 32'd65537);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
